// File: rtl/twos_comp_arbiter.sv
// Round-robin arbiter sharing one two's-complement negate/abs unit behind a registered output stage.
// Define TWOS_COMP_SATURATE_EN to saturate neg/abs of the most negative value to the maximum.
module twos_comp_arbiter #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*2-1:0]      req_op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_id,
    output logic                      out_ovf
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    localparam logic [1:0] OpPass   = 2'b00;
    localparam logic [1:0] OpNeg    = 2'b01;
    localparam logic [1:0] OpAbs    = 2'b10;
    localparam logic [1:0] OpNegAbs = 2'b11;

    localparam logic [DATA_W-1:0] MinVal = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MaxVal = {1'b0, {(DATA_W-1){1'b1}}};

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [ID_W-1:0]     out_id_q, out_id_d;
    logic                out_ovf_q, out_ovf_d;

    logic                can_load;
    logic                grant;
    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;
    int unsigned         scan_idx;
    logic [DATA_W-1:0]   sel_data;
    logic [1:0]          sel_op;
    logic [DATA_W-1:0]   neg_data;
    logic                is_min;
    logic [DATA_W-1:0]   res_data;
    logic                res_ovf;

    // Rotating priority search starting at rr_ptr_q.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        sel_data    = '0;
        sel_op      = OpPass;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = (32'(rr_ptr_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(scan_idx);
                sel_data    = req_data[scan_idx*DATA_W +: DATA_W];
                sel_op      = req_op[scan_idx*2 +: 2];
            end
        end
    end

    always_comb begin
        neg_data = ~sel_data + 1'b1;
        is_min   = (sel_data == MinVal);
        res_data = sel_data;
        res_ovf  = 1'b0;
        unique case (sel_op)
            OpPass:   res_data = sel_data;
            OpNeg: begin
                res_data = neg_data;
                res_ovf  = is_min;
            end
            OpAbs: begin
                res_data = sel_data[DATA_W-1] ? neg_data : sel_data;
                res_ovf  = is_min;
            end
            OpNegAbs: res_data = sel_data[DATA_W-1] ? sel_data : neg_data;
            default:  res_data = sel_data;
        endcase
`ifdef TWOS_COMP_SATURATE_EN
        if (res_ovf) begin
            res_data = MaxVal;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (grant) state_d = StFull;
            StFull:  if (out_ready && !grant) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    // rst_n gating keeps req_ready low for the whole reset, not just after the first edge.
    always_comb begin
        out_valid = (state_q == StFull);
        can_load  = (state_q == StEmpty) || (out_ready && out_valid);
        grant     = can_load && grant_found && rst_n;
        req_ready = '0;
        if (grant) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        out_ovf_d  = out_ovf_q;
        if (grant) begin
            rr_ptr_d   = ID_W'((32'(grant_idx) + 1) % NUM_REQ);
            out_data_d = res_data;
            out_id_d   = grant_idx;
            out_ovf_d  = res_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            out_data_q <= '0;
            out_id_q   <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    assign out_data = out_data_q;
    assign out_id   = out_id_q;
    assign out_ovf  = out_ovf_q;

endmodule
